datapath_feeder: RTL and testbench

- Front-end sequencer that feeds the neuron datapath.
- Takes one valid/ready word stream per neuron job and splits it into the data, weight and bias buffer write ports.
- Waits for all three buffers to report ready, then fires the read/load strobes.
- Waits for neuron_done, captures neuron_out and returns it on a valid/ready result port.

---
 rtl/datapath_feeder_pkg.sv | 20 ++
 rtl/feeder_word_router.sv | 53 +++++
 rtl/datapath_feeder.sv | 139 +++++++++++++
 tb/tb_datapath_feeder.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/datapath_feeder_pkg.sv
// Shared types and default sizes for the neuron datapath feeder.
// States cover the job flow from word loading through result return.
package datapath_feeder_pkg;

  localparam int DWIDTH_DEF  = 16;
  localparam int IN_SIZE_DEF = 64;
  localparam int TIMEOUT_DEF = 4096;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_DATA,
    LOAD_WEIGHT,
    LOAD_BIAS,
    WAIT_READY,
    FIRE,
    WAIT_DONE,
    OUTPUT
  } feeder_state_t;

endpackage

// File: rtl/feeder_word_router.sv
// Registered demux of one accepted stream word onto the data, weight
// or bias buffer write port selected by the current load phase.
module feeder_word_router
  import datapath_feeder_pkg::*;
#(
  parameter int DWIDTH = DWIDTH_DEF
) (
  input  logic              clk,
  input  logic              nreset,
  input  logic              accept,
  input  feeder_state_t     phase,
  input  logic [DWIDTH-1:0] word,
  output logic              we_data,
  output logic              we_weight,
  output logic              we_bias,
  output logic [DWIDTH-1:0] input_data,
  output logic [DWIDTH-1:0] input_weight,
  output logic [DWIDTH-1:0] input_bias
);

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      we_data      <= 1'b0;
      we_weight    <= 1'b0;
      we_bias      <= 1'b0;
      input_data   <= '0;
      input_weight <= '0;
      input_bias   <= '0;
    end else begin
      we_data   <= 1'b0;
      we_weight <= 1'b0;
      we_bias   <= 1'b0;
      if (accept) begin
        unique case (1'b1)
          (phase == LOAD_DATA): begin
            we_data    <= 1'b1;
            input_data <= word;
          end
          (phase == LOAD_WEIGHT): begin
            we_weight    <= 1'b1;
            input_weight <= word;
          end
          (phase == LOAD_BIAS): begin
            we_bias    <= 1'b1;
            input_bias <= word;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: rtl/datapath_feeder.sv
// Job sequencer feeding the neuron datapath: load, fire, collect result.
// Define FEEDER_TIMEOUT_EN to add the WAIT_DONE watchdog (timeout_err).
module datapath_feeder
  import datapath_feeder_pkg::*;
#(
  parameter int DWIDTH         = DWIDTH_DEF,
  parameter int IN_SIZE        = IN_SIZE_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              nreset,
  input  logic              en,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DWIDTH-1:0] s_data,
  output logic              we_data,
  output logic              we_weight,
  output logic              we_bias,
  output logic [DWIDTH-1:0] input_data,
  output logic [DWIDTH-1:0] input_weight,
  output logic [DWIDTH-1:0] input_bias,
  input  logic              buf_ready_data,
  input  logic              buf_ready_weight,
  input  logic              buf_ready_bias,
  output logic              re_data,
  output logic              re_weight,
  output logic              re_bias,
  output logic              load_en,
  input  logic [DWIDTH-1:0] neuron_out,
  input  logic              neuron_done,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DWIDTH-1:0] m_data,
  output logic              busy,
  output logic              timeout_err
);

  localparam int CW = $clog2(IN_SIZE + 1);

  feeder_state_t state, state_nx;
  logic [CW-1:0] cnt;
  logic          accept;
  logic          last;
  logic          all_ready;
  logic          fire_q;
  logic          tmo;

  assign s_ready = (state == LOAD_DATA) |
                   (state == LOAD_WEIGHT) |
                   (state == LOAD_BIAS);
  assign accept  = s_valid & s_ready;
  assign last    = (state == LOAD_BIAS) |
                   (cnt == CW'(IN_SIZE - 1));
  assign all_ready = buf_ready_data &
                     buf_ready_weight &
                     buf_ready_bias;
  assign busy    = (state != IDLE);
  assign m_valid = (state == OUTPUT);

  assign re_data   = fire_q;
  assign re_weight = fire_q;
  assign re_bias   = fire_q;
  assign load_en   = fire_q;

`ifdef FEEDER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tcnt;
  logic          terr;

  assign tmo = (state == WAIT_DONE) & ~neuron_done &
               (tcnt == TW'(TIMEOUT_CYCLES - 1));
  assign timeout_err = terr;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      tcnt <= '0;
      terr <= 1'b0;
    end else begin
      if (state != WAIT_DONE) tcnt <= '0;
      else tcnt <= tcnt + TW'(1);
      if (tmo) terr <= 1'b1;
    end
  end
`else
  assign tmo         = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:        if (en) state_nx = LOAD_DATA;
      LOAD_DATA:   if (accept && last) state_nx = LOAD_WEIGHT;
      LOAD_WEIGHT: if (accept && last) state_nx = LOAD_BIAS;
      LOAD_BIAS:   if (accept) state_nx = WAIT_READY;
      WAIT_READY:  if (all_ready) state_nx = FIRE;
      FIRE:        state_nx = WAIT_DONE;
      WAIT_DONE: begin
        if (neuron_done) state_nx = OUTPUT;
        else if (tmo) state_nx = IDLE;
      end
      OUTPUT:      if (m_ready) state_nx = IDLE;
      default:     state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state  <= IDLE;
      cnt    <= '0;
      fire_q <= 1'b0;
      m_data <= '0;
    end else begin
      state  <= state_nx;
      fire_q <= (state == WAIT_READY) & all_ready;
      if (state != state_nx) cnt <= '0;
      else if (accept) cnt <= cnt + CW'(1);
      if (state == WAIT_DONE && neuron_done)
        m_data <= neuron_out;
    end
  end

  feeder_word_router #(
    .DWIDTH(DWIDTH)
  ) u_router (
    .clk         (clk),
    .nreset      (nreset),
    .accept      (accept),
    .phase       (state),
    .word        (s_data),
    .we_data     (we_data),
    .we_weight   (we_weight),
    .we_bias     (we_bias),
    .input_data  (input_data),
    .input_weight(input_weight),
    .input_bias  (input_bias)
  );

endmodule

// File: tb/tb_datapath_feeder.sv
// Directed scoreboard bench for datapath_feeder with IN_SIZE=4.
// Build with FEEDER_TIMEOUT_EN to include the watchdog scenario.
module tb_datapath_feeder;

  localparam int DW = 16;
  localparam int N  = 4;

  logic          clk = 1'b0;
  logic          nreset = 1'b0;
  logic          en = 1'b0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [DW-1:0] s_data = '0;
  logic          we_data, we_weight, we_bias;
  logic [DW-1:0] input_data, input_weight, input_bias;
  logic          buf_ready_data = 1'b1;
  logic          buf_ready_weight = 1'b1;
  logic          buf_ready_bias = 1'b1;
  logic          re_data, re_weight, re_bias, load_en;
  logic [DW-1:0] neuron_out = '0;
  logic          neuron_done = 1'b0;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [DW-1:0] m_data;
  logic          busy;
  logic          timeout_err;

  int total = 0;
  int bad = 0;
  int hs = 0;
  int fires = 0;

  logic [18:0]   wq[$];
  logic [DW-1:0] rq[$];

  datapath_feeder #(
    .DWIDTH(DW),
    .IN_SIZE(N),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk),
    .nreset(nreset),
    .en(en),
    .s_valid(s_valid),
    .s_ready(s_ready),
    .s_data(s_data),
    .we_data(we_data),
    .we_weight(we_weight),
    .we_bias(we_bias),
    .input_data(input_data),
    .input_weight(input_weight),
    .input_bias(input_bias),
    .buf_ready_data(buf_ready_data),
    .buf_ready_weight(buf_ready_weight),
    .buf_ready_bias(buf_ready_bias),
    .re_data(re_data),
    .re_weight(re_weight),
    .re_bias(re_bias),
    .load_en(load_en),
    .neuron_out(neuron_out),
    .neuron_done(neuron_done),
    .m_valid(m_valid),
    .m_ready(m_ready),
    .m_data(m_data),
    .busy(busy),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Monitor samples 1 time unit after the falling edge.
  always begin
    logic [18:0]   e;
    logic [DW-1:0] wd;
    @(negedge clk);
    #1;
    if (we_data | we_weight | we_bias) begin
      chk("we_onehot", 32'(we_data + we_weight + we_bias), 1);
      if (wq.size() == 0) begin
        chk("unexpected_write", {we_data, we_weight, we_bias}, 0);
      end else begin
        e = wq.pop_front();
        wd = we_data ? input_data :
             we_weight ? input_weight : input_bias;
        chk("write_kind", {we_data, we_weight, we_bias}, e[18:16]);
        chk("write_word", wd, e[15:0]);
      end
    end
    if (load_en) fires++;
    if (m_valid && m_ready) begin
      hs++;
      if (rq.size() == 0) chk("unexpected_result", m_data, 0);
      else chk("result_data", m_data, rq.pop_front());
    end
  end

  // Call at a falling edge; returns at the falling edge after accept.
  task automatic send(input logic [2:0] kind, input logic [DW-1:0] w);
    int n = 0;
    s_valid = 1'b1;
    s_data  = w;
    while (!s_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("s_ready_wait", s_ready, 1);
    wq.push_back({kind, w});
    @(negedge clk);
  endtask

  task automatic idle(input int cycles);
    s_valid = 1'b0;
    repeat (cycles) @(negedge clk);
  endtask

  task automatic feed(input logic [DW-1:0] db, input logic [DW-1:0] wb,
                      input logic [DW-1:0] b, input bit stall);
    for (int i = 0; i < N; i++) begin
      send(3'b100, db + DW'(i));
      if (stall && i[0]) idle(1);
    end
    for (int i = 0; i < N; i++) begin
      send(3'b010, wb + DW'(i));
      if (stall && i[0]) idle(1);
    end
    send(3'b001, b);
    idle(0);
  endtask

  task automatic wait_load();
    int n = 0;
    while (!load_en && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("load_en_seen", load_en, 1);
    chk("re_all", {re_data, re_weight, re_bias}, 3'b111);
  endtask

  task automatic finish_job(input logic [DW-1:0] val, input int hold);
    int h0;
    h0 = hs;
    wait_load();
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      if (i == 1) chk("load_en_single", load_en, 0);
    end
    neuron_done = 1'b1;
    neuron_out  = val;
    rq.push_back(val);
    @(negedge clk);
    neuron_done = 1'b0;
    neuron_out  = 16'hFFFF;
    for (int i = 0; i < hold; i++) begin
      chk("m_valid_hold", m_valid, 1);
      chk("m_data_hold", m_data, val);
      @(negedge clk);
    end
    chk("m_valid_pre", m_valid, 1);
    m_ready = 1'b1;
    @(negedge clk);
    m_ready = 1'b0;
    chk("m_valid_drop", m_valid, 0);
    chk("busy_idle", busy, 0);
    #2;
    chk("one_handshake", 32'(hs - h0), 1);
  endtask

  initial begin
    int f0;
    #3;
    chk("rst_s_ready", s_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_strobes", {we_data, we_weight, we_bias, load_en, re_data}, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_words", {input_data, input_weight}, 0);
    chk("rst_m_data", {input_bias, m_data}, 0);
    chk("rst_terr", timeout_err, 0);
    @(negedge clk);
    nreset = 1'b1;
    @(negedge clk);
    chk("idle_no_en", busy, 0);

    // Nominal job
    en = 1'b1;
    feed(16'h0001, 16'h0010, 16'h0100, 1'b0);
    finish_job(16'h1234, 3);
    @(negedge clk);
    chk("en_relaunch", s_ready, 1);

    // Input and output stalls; en dropped mid-job
    s_valid = 1'b1;
    send(3'b100, 16'h0200);
    en = 1'b0;
    for (int i = 1; i < N; i++) begin
      send(3'b100, 16'h0200 + DW'(i));
      if (i[0]) idle(1);
    end
    for (int i = 0; i < N; i++) begin
      send(3'b010, 16'h0300 + DW'(i));
      if (i[0]) idle(1);
    end
    send(3'b001, 16'h0400);
    idle(0);
    finish_job(16'h0BEE, 5);
    repeat (2) @(negedge clk);
    chk("stay_idle_en0", busy, 0);
    en = 1'b1;

    // Ready gating on bias buffer
    buf_ready_bias = 1'b0;
    f0 = fires;
    feed(16'h0500, 16'h0600, 16'h0700, 1'b0);
    for (int i = 0; i < 10; i++) begin
      chk("gate_no_load", load_en, 0);
      chk("gate_busy", busy, 1);
      @(negedge clk);
    end
    buf_ready_bias = 1'b1;
    chk("gate_same_cycle", load_en, 0);
    @(negedge clk);
    chk("gate_fire_next", load_en, 1);
    finish_job(16'h0555, 0);
    chk("gate_one_fire", 32'(fires - f0), 1);

    // Spurious done during LOAD_DATA
    send(3'b100, 16'h0800);
    send(3'b100, 16'h0801);
    s_valid = 1'b0;
    neuron_done = 1'b1;
    neuron_out  = 16'hDEAD;
    @(negedge clk);
    neuron_done = 1'b0;
    chk("spur_no_valid", m_valid, 0);
    send(3'b100, 16'h0802);
    send(3'b100, 16'h0803);
    for (int i = 0; i < N; i++) send(3'b010, 16'h0900 + DW'(i));
    send(3'b001, 16'h0A00);
    idle(0);
    finish_job(16'h0042, 1);

    // Reset in the middle of LOAD_WEIGHT
    for (int i = 0; i < N; i++) send(3'b100, 16'h0B00 + DW'(i));
    send(3'b010, 16'h0C00);
    send(3'b010, 16'h0C01);
    idle(1);
    nreset = 1'b0;
    #2;
    chk("mid_rst_ready", s_ready, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_we", {we_data, we_weight, we_bias, load_en}, 0);
    chk("mid_rst_words", {input_data, input_weight}, 0);
    chk("mid_rst_mdata", {input_bias, m_data}, 0);
    chk("mid_rst_wq", wq.size(), 0);
    @(negedge clk);
    nreset = 1'b1;
    feed(16'h0D00, 16'h0E00, 16'h0F00, 1'b1);
    finish_job(16'h0077, 2);

`ifdef FEEDER_TIMEOUT_EN
    f0 = hs;
    feed(16'h1100, 16'h1200, 16'h1300, 1'b0);
    wait_load();
    en = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      chk("tmo_wait_err", timeout_err, 0);
      chk("tmo_wait_busy", busy, 1);
      chk("tmo_no_valid", m_valid, 0);
    end
    @(negedge clk);
    chk("tmo_err_set", timeout_err, 1);
    chk("tmo_idle", busy, 0);
    repeat (3) @(negedge clk);
    chk("tmo_sticky", timeout_err, 1);
    chk("tmo_no_hs", 32'(hs - f0), 0);
`else
    chk("terr_tied", timeout_err, 0);
`endif

    #2;
    chk("wq_empty", wq.size(), 0);
    chk("rq_empty", rq.size(), 0);
    chk("hs_total", hs, 5);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    bad++;
    $display("FAIL watchdog observed=timeout expected=finish");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "bench timeout");
  end

endmodule
